// File: rtl/mul_pkg.sv
// mul_pkg: widths shared by the multiplier and the product accumulation stage.
`default_nettype none

package mul_pkg;
    localparam int unsigned OP_W       = 32;
    localparam int unsigned PROD_W     = 64;
    localparam int unsigned BEAT_W_DEF = 16;

    typedef logic [PROD_W-1:0] prod_t;
endpackage : mul_pkg

`default_nettype wire

// File: rtl/prod_out_fifo.sv
// ============================================================================
// prod_out_fifo: DEPTH-entry result buffer {data, ovf, beats} with registered
// ready (count < DEPTH). Rev 1.0
// ============================================================================
`default_nettype none

module prod_out_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned BEAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ovf,
    input  logic [BEAT_W-1:0] i_beats,
    input  logic              i_pop,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_ovf,
    output logic [BEAT_W-1:0] o_beats
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic              r_ovf_mem  [DEPTH];
    logic [BEAT_W-1:0] r_beat_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ready;

    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [PTR_W-1:0]  w_wr_nxt;
    logic [PTR_W-1:0]  w_rd_nxt;

    assign w_push   = i_push & r_ready;
    assign w_pop    = i_pop & (r_count != '0);
    assign w_wr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Memory is cleared on reset so every output reads zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_data_mem[i] <= '0;
                r_ovf_mem[i]  <= 1'b0;
                r_beat_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_data_mem[r_wr_ptr] <= i_data;
                r_ovf_mem[r_wr_ptr]  <= i_ovf;
                r_beat_mem[r_wr_ptr] <= i_beats;
                r_wr_ptr             <= w_wr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt < CNT_W'(DEPTH));
        end
    end

    assign o_ready = r_ready;
    assign o_valid = (r_count != '0);
    assign o_data  = r_data_mem[r_rd_ptr];
    assign o_ovf   = r_ovf_mem[r_rd_ptr];
    assign o_beats = r_beat_mem[r_rd_ptr];
endmodule : prod_out_fifo

`default_nettype wire

// File: rtl/prod_acc_stage.sv
// ============================================================================
// prod_acc_stage: accumulates 64-bit product beats into group sums (or passes
// them through) and buffers results. Option macro: PROD_ACC_SAT_EN. Rev 1.0
// ============================================================================
`default_nettype none

module prod_acc_stage
    import mul_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned BEAT_W = BEAT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    input  logic              acc_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_data,
    output logic              out_ovf,
    output logic [BEAT_W-1:0] out_beats
);
    logic [PROD_W-1:0] r_acc;
    logic              r_ovf;
    logic [BEAT_W-1:0] r_beat_cnt;

    logic              w_accept;
    logic [PROD_W:0]   w_sum;
    logic              w_grp_ovf;
    logic [PROD_W-1:0] w_grp_data;
    logic [BEAT_W-1:0] w_beat_inc;
    logic              w_push;
    logic [PROD_W-1:0] w_push_data;
    logic              w_push_ovf;
    logic [BEAT_W-1:0] w_push_beats;

    assign w_accept   = in_valid & in_ready;
    assign w_sum      = {1'b0, r_acc} + {1'b0, in_prod};
    assign w_grp_ovf  = r_ovf | w_sum[PROD_W];
    assign w_beat_inc = (&r_beat_cnt) ? r_beat_cnt : r_beat_cnt + BEAT_W'(1);

`ifdef PROD_ACC_SAT_EN
    assign w_grp_data = w_grp_ovf ? {PROD_W{1'b1}} : w_sum[PROD_W-1:0];
`else
    assign w_grp_data = w_sum[PROD_W-1:0];
`endif

    // Pass-through beats bypass the accumulator and never disturb a group in progress.
    assign w_push       = w_accept & (~acc_en | in_last);
    assign w_push_data  = acc_en ? w_grp_data : in_prod;
    assign w_push_ovf   = acc_en & w_grp_ovf;
    assign w_push_beats = acc_en ? w_beat_inc : BEAT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_beat_cnt <= '0;
        end else if (w_accept && acc_en) begin
            if (in_last) begin
                r_acc      <= '0;
                r_ovf      <= 1'b0;
                r_beat_cnt <= '0;
            end else begin
                r_acc      <= w_sum[PROD_W-1:0];
                r_ovf      <= w_grp_ovf;
                r_beat_cnt <= w_beat_inc;
            end
        end
    end

    prod_out_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (PROD_W),
        .BEAT_W (BEAT_W)
    ) u_out_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_ovf   (w_push_ovf),
        .i_beats (w_push_beats),
        .i_pop   (out_ready),
        .o_ready (in_ready),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_ovf   (out_ovf),
        .o_beats (out_beats)
    );
endmodule : prod_acc_stage

`default_nettype wire
